// File: rtl/ins_queue.sv
// ins_queue: instruction-parcel queue between instruction fetch and decode.
//
// Issues word fetches ahead of the decoder and splits each returned FW-bit
// word into 16-bit parcels. It holds up to DEPTH parcels and presents the
// head parcel and its PC over a valid/ready handshake. It also handles
// branch redirects to any halfword, including redirects that land while a
// fetch is still in flight.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   fetch_req    one-cycle pulse issuing a fetch of fetch_addr
//   fetch_addr   word-aligned address of the fetch being issued
//   fetch_done   one-cycle pulse, fetch_data valid for the outstanding fetch
//   fetch_data   fetched word, lower-address parcel in bits [15:0]
//   redirect     one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc  new PC (bit 0 ignored)
//   ins          head parcel (meaningful while idone=1)
//   ins_pc       address of the head parcel
//   idone        head parcel valid
//   iready       decoder accepts the head parcel this cycle
//   count        number of parcels held
module ins_queue #(
    parameter int              RV       = 32,
    parameter int              FW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [RV-1:0]   RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       fetch_req,
    output logic [RV-1:0]              fetch_addr,
    input  logic                       fetch_done,
    input  logic [FW-1:0]              fetch_data,
    input  logic                       redirect,
    input  logic [RV-1:0]              redirect_pc,
    output logic [15:0]                ins,
    output logic [RV-1:0]              ins_pc,
    output logic                       idone,
    input  logic                       iready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int NP  = FW / 16;            // parcels per fetch word
    localparam int PW  = $clog2(DEPTH);      // pointer width
    localparam int CW  = $clog2(DEPTH + 1);  // count width
    localparam int AB  = FW / 8;             // bytes per fetch word
    localparam int ALB = $clog2(AB);         // address bits below word alignment

    localparam logic [RV-1:0] RST_FADDR = {RESET_PC[RV-1:ALB], {ALB{1'b0}}};
    localparam logic [RV-1:0] RST_PC    = {RESET_PC[RV-1:1], 1'b0};
    localparam logic          RST_SKIP  = (FW == 32) ? RESET_PC[1] : 1'b0;
    localparam logic [CW-1:0] ISSUE_MAX = CW'(DEPTH - NP);

    logic [15:0]    mem_q [DEPTH];
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [RV-1:0]  pc_q, pc_d;
    logic [RV-1:0]  faddr_q, faddr_d;
    logic           out_q, out_d;      // a fetch is outstanding
    logic           stale_q, stale_d;  // outstanding fetch was overtaken by a redirect
    logic           skip_q, skip_d;    // drop the lower parcel of the next return

    logic           idone_s;
    logic           pop_s;
    logic           push_s;
    logic           issue_s;
    logic [CW-1:0]  push_n_s;
    logic [CW-1:0]  add_s;
    logic [CW-1:0]  sub_s;
    logic [15:0]    slot0_s;
    logic           unused_s;

    assign unused_s = redirect_pc[0];

    assign idone_s  = (count_q != {CW{1'b0}});
    // Gated with reset so no fetch is requested while reset is held.
    assign issue_s  = reset && !out_q && !redirect && (count_q <= ISSUE_MAX);
    assign pop_s    = idone_s && iready && !redirect;
    assign push_s   = fetch_done && out_q && !stale_q && !redirect;
    assign push_n_s = skip_q ? CW'(1) : CW'(NP);
    assign add_s    = push_s ? push_n_s : {CW{1'b0}};
    assign sub_s    = pop_s ? CW'(1) : {CW{1'b0}};
    // When skipping, the upper parcel lands in the first free slot.
    assign slot0_s  = skip_q ? fetch_data[FW-1 -: 16] : fetch_data[15:0];

    assign fetch_req  = issue_s;
    assign fetch_addr = faddr_q;
    assign ins        = mem_q[rd_q];
    assign ins_pc     = pc_q;
    assign idone      = idone_s;
    assign count      = count_q;

    // Next-state logic for pointers, count, PCs and fetch bookkeeping.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        out_d   = out_q;
        stale_d = stale_q;
        skip_d  = skip_q;
        if (redirect) begin
            rd_d    = {PW{1'b0}};
            wr_d    = {PW{1'b0}};
            count_d = {CW{1'b0}};
            pc_d    = {redirect_pc[RV-1:1], 1'b0};
            faddr_d = {redirect_pc[RV-1:ALB], {ALB{1'b0}}};
            skip_d  = (FW == 32) && redirect_pc[1];
            if (out_q && fetch_done) begin
                // The in-flight fetch completes now; nothing left to discard.
                out_d   = 1'b0;
                stale_d = 1'b0;
            end else if (out_q) begin
                stale_d = 1'b1;
            end else begin
                stale_d = stale_q;
            end
        end else begin
            if (pop_s) begin
                rd_d = rd_q + PW'(1);
                pc_d = pc_q + RV'(2);
            end else begin
                rd_d = rd_q;
                pc_d = pc_q;
            end
            if (push_s) begin
                wr_d = wr_q + PW'(push_n_s);
            end else begin
                wr_d = wr_q;
            end
            count_d = count_q + add_s - sub_s;
            if (issue_s) begin
                out_d   = 1'b1;
                faddr_d = faddr_q + RV'(AB);
            end else if (out_q && fetch_done) begin
                out_d   = 1'b0;
                stale_d = 1'b0;
                if (!stale_q) begin
                    skip_d = 1'b0;
                end else begin
                    skip_d = skip_q;
                end
            end else begin
                out_d = out_q;
            end
        end
    end

    // Control and address state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= {PW{1'b0}};
            wr_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            pc_q    <= RST_PC;
            faddr_q <= RST_FADDR;
            out_q   <= 1'b0;
            stale_q <= 1'b0;
            skip_q  <= RST_SKIP;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            out_q   <= out_d;
            stale_q <= stale_d;
            skip_q  <= skip_d;
        end
    end

    // Parcel storage: write returned parcels in ascending address order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (push_s) begin
            mem_q[wr_q] <= slot0_s;
            if ((NP == 2) && !skip_q) begin
                mem_q[wr_q + PW'(1)] <= fetch_data[FW-1 -: 16];
            end
        end
    end

endmodule
